// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one DATA_BITS word per frame onto a registered,
// idle-high line. Frame = start(0), data LSB-first, optional parity, stop bit(s).
// A single internal divider times every serial bit at CLKS_PER_BIT clocks.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int              DIV_W     = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state;
    logic [DIV_W-1:0]     div;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;

    // Parity bit for a word: even parity is the XOR of the bits, odd inverts it.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // Frame sequencer: every state lasts CLKS_PER_BIT clocks per bit; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            div      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    div     <= '0;
                    bit_idx <= '0;
                    if (tx_valid && tx_ready) begin
                        shreg    <= tx_data;
                        par      <= parity_of(tx_data);
                        state    <= START;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DATA: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= par;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            // tx mirrors the bit that becomes shreg[0] after this shift
                            bit_idx <= bit_idx + 4'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                PARITY: begin
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx  <= '0;
                            state    <= IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        div <= div + 1'b1;
                        // registered pulse lands in the very last clock of the last stop bit
                        if (div == DIV_PRE && bit_idx == STOP_LAST) begin
                            tx_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    div      <= '0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: four differently configured instances share
// clock and reset. Stimulus pushes the expected line waveform of each accepted
// word into a per-instance queue; per-instance monitors pop and compare.
module tb_uart_transmitter;

    localparam int NI = 4;
    localparam int CPB [NI] = '{8, 8, 3, 4};
    localparam int DB  [NI] = '{8, 8, 5, 7};
    localparam int PE  [NI] = '{0, 1, 1, 0};
    localparam int PO  [NI] = '{0, 0, 1, 0};
    localparam int SB  [NI] = '{1, 1, 1, 2};

    typedef struct {
        logic [12:0] bits;
        int          n;
        bit          b2b;
    } frame_t;

    logic          clk;
    logic          reset;
    logic [NI-1:0] valid;
    logic [8:0]    data [NI];
    logic [NI-1:0] txl, rdy, bsy, dn;
    logic          rst_at_edge;

    int checks   = 0;
    int failures = 0;

    frame_t sbq [NI][$];

    uart_transmitter #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(DB[0]), .PARITY_EN(PE[0]),
                       .PARITY_ODD(PO[0]), .STOP_BITS(SB[0])) u0 (
        .clk(clk), .reset(reset), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
        .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]), .tx_done(dn[0]));
    uart_transmitter #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(DB[1]), .PARITY_EN(PE[1]),
                       .PARITY_ODD(PO[1]), .STOP_BITS(SB[1])) u1 (
        .clk(clk), .reset(reset), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
        .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]), .tx_done(dn[1]));
    uart_transmitter #(.CLKS_PER_BIT(CPB[2]), .DATA_BITS(DB[2]), .PARITY_EN(PE[2]),
                       .PARITY_ODD(PO[2]), .STOP_BITS(SB[2])) u2 (
        .clk(clk), .reset(reset), .tx_valid(valid[2]), .tx_data(data[2][4:0]),
        .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]), .tx_done(dn[2]));
    uart_transmitter #(.CLKS_PER_BIT(CPB[3]), .DATA_BITS(DB[3]), .PARITY_EN(PE[3]),
                       .PARITY_ODD(PO[3]), .STOP_BITS(SB[3])) u3 (
        .clk(clk), .reset(reset), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
        .tx_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]), .tx_done(dn[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember whether the most recent edge applied reset.
    always @(posedge clk) rst_at_edge <= reset;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t actual=%0h expected=%0h", nm, g, $time, act, exp);
        end
    endtask

    // Line levels of one frame, bit by bit, built from the frame format rules.
    function automatic frame_t make_frame(input int g, input logic [8:0] d, input bit b2b);
        frame_t f;
        int ones = 0;
        f.bits = '0;
        f.n    = 0;
        f.b2b  = b2b;
        f.bits[f.n] = 1'b0;
        f.n++;
        for (int i = 0; i < DB[g]; i++) begin
            f.bits[f.n] = d[i];
            if (d[i]) ones++;
            f.n++;
        end
        if (PE[g] != 0) begin
            f.bits[f.n] = ((ones % 2) != 0) ^ (PO[g] != 0);
            f.n++;
        end
        for (int s = 0; s < SB[g]; s++) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : mon
        localparam int C = CPB[g];
        int     pos        = -1;
        int     cyc        = 0;
        int     last_start = 0;
        bit     live       = 1'b0;
        frame_t cur;

        // Per-instance monitor: compare the line, handshake and done pulse every clock.
        always @(negedge clk) begin
            cyc++;
            if (rst_at_edge === 1'b1) begin
                live = 1'b1;
                pos  = -1;
                chk("reset_tx", g, 32'(txl[g]), 32'd1);
                chk("reset_ready", g, 32'(rdy[g]), 32'd1);
                chk("reset_busy", g, 32'(bsy[g]), 32'd0);
                chk("reset_done", g, 32'(dn[g]), 32'd0);
            end else if (live) begin
                if (pos < 0) begin
                    if (txl[g] === 1'b0) begin
                        if (sbq[g].size() == 0) begin
                            chk("unexpected_frame", g, 32'd1, 32'd0);
                        end else begin
                            cur = sbq[g].pop_front();
                            pos = 0;
                            if (cur.b2b) chk("b2b_spacing", g, 32'(cyc - last_start), 32'(cur.n * C + 1));
                            last_start = cyc;
                        end
                    end else begin
                        chk("idle_tx", g, 32'(txl[g]), 32'd1);
                        chk("idle_ready", g, 32'(rdy[g]), 32'd1);
                        chk("idle_busy", g, 32'(bsy[g]), 32'd0);
                        chk("idle_done", g, 32'(dn[g]), 32'd0);
                    end
                end
                if (pos >= 0) begin
                    chk("frame_tx", g, 32'(txl[g]), 32'(cur.bits[pos / C]));
                    chk("frame_ready", g, 32'(rdy[g]), 32'd0);
                    chk("frame_busy", g, 32'(bsy[g]), 32'd1);
                    chk("frame_done", g, 32'(dn[g]), (pos == cur.n * C - 1) ? 32'd1 : 32'd0);
                    pos++;
                    if (pos == cur.n * C) pos = -1;
                end
            end
        end
    end

    task automatic wait_idle(input int g);
        int t = 0;
        while (rdy[g] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("ready_timeout", g, 32'(rdy[g]), 32'd1);
    endtask

    // Offer a word when ready; the edge that sees valid&ready is the accept edge.
    task automatic send(input int g, input logic [8:0] d, input bit b2b, input bit hold);
        wait_idle(g);
        valid[g] = 1'b1;
        data[g]  = d;
        @(posedge clk);
        sbq[g].push_back(make_frame(g, d, b2b));
        @(negedge clk);
        if (!hold) valid[g] = 1'b0;
    endtask

    task automatic run_random(input int g, input int n);
        bit hold_prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [8:0] d;
            bit         h;
            d = 9'($urandom);
            h = (i < n - 1) && ($urandom_range(0, 1) == 1);
            if (!hold_prev) repeat ($urandom_range(0, 5)) @(negedge clk);
            send(g, d, hold_prev, h);
            hold_prev = h;
        end
        wait_idle(g);
    endtask

    initial begin
        reset = 1'b1;
        valid = '0;
        for (int i = 0; i < NI; i++) data[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send(0, 9'h0A5, 1'b0, 1'b0); wait_idle(0);
        send(1, 9'h007, 1'b0, 1'b0); wait_idle(1);
        send(2, 9'h007, 1'b0, 1'b0); wait_idle(2);
        send(3, 9'h055, 1'b0, 1'b0); wait_idle(3);

        // valid held high across two words
        send(0, 9'h000, 1'b0, 1'b1);
        send(0, 9'h0FF, 1'b1, 1'b0);
        wait_idle(0);

        // valid/data wiggle while busy must be ignored
        send(0, 9'h03C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 9'h0C3;
        repeat (3) @(negedge clk);
        valid[0] = 1'b0;
        wait_idle(0);

        // reset in the middle of a frame, then a normal frame
        send(0, 9'h05A, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send(0, 9'h0E1, 1'b0, 1'b0);
        wait_idle(0);

        fork
            run_random(0, 8);
            run_random(1, 8);
            run_random(2, 8);
            run_random(3, 8);
        join

        repeat (20) @(negedge clk);
        for (int i = 0; i < NI; i++) chk("pending_frames", i, 32'(sbq[i].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
